// File: rtl/counter_reader_pkg.sv
// Shared types and width helpers for the asynchronous event counter reader.
package counter_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_CLEAR,
        ST_CLEAR_WAIT,
        ST_DONE
    } reader_state_t;

    // Width of a counter that must hold values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/counter_reader_synchronizer.sv
// Two-flop bus synchronizer bringing the free-running counter value into clk.
module counter_reader_synchronizer
    import counter_reader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage1 <= '0;
            q      <= '0;
        end else begin
            stage1 <= d;
            q      <= stage1;
        end
    end

endmodule

// File: rtl/counter_reader.sv
// Reader/controller for an asynchronous event counter: coherent snapshots and clear sequencing.
//
// state         | meaning
// --------------+--------------------------------------------------------------
// ST_IDLE       | ready for a read or clear request (clear has priority)
// ST_SAMPLE     | waiting for STABLE_SAMPLES consecutive equal samples
// ST_CLEAR      | counter_clear asserted for CLEAR_CYCLES cycles
// ST_CLEAR_WAIT | waiting until two consecutive synchronized samples read zero
// ST_DONE       | snapshot latched; read_valid pulses on exit
module counter_reader
    import counter_reader_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int STABLE_SAMPLES = 2,
    parameter int MAX_TRIES      = 16,
    parameter int CLEAR_CYCLES   = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] count_in,
    input  logic             count_enable,
    input  logic             read_req,
    input  logic             clear_req,
    output logic             read_ready,
    output logic             read_valid,
    output logic [WIDTH-1:0] read_value,
    output logic             read_error,
    output logic             clear_done,
    output logic             counter_enable,
    output logic             counter_clear
);

    localparam int CNT_W = cnt_width(MAX_TRIES);
    localparam int CLR_W = cnt_width(CLEAR_CYCLES);
    localparam logic [CNT_W-1:0] STABLE_N = CNT_W'(STABLE_SAMPLES);
    localparam logic [CNT_W-1:0] TRIES_N  = CNT_W'(MAX_TRIES);
    localparam logic [CLR_W-1:0] CLEAR_N  = CLR_W'(CLEAR_CYCLES);

    reader_state_t    state;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] prev;
    logic             match;
    logic             sync_zero;
    logic [CNT_W-1:0] try_cnt;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] try_next;
    logic [CNT_W-1:0] match_next;
    logic [CLR_W-1:0] clr_cnt;
    logic [CLR_W-1:0] clr_next;

    counter_reader_synchronizer #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (count_in),
        .q       (sync)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= '0;
        end else begin
            prev <= sync;
        end
    end

    assign match      = (sync == prev);
    assign sync_zero  = (sync == '0) && (prev == '0);
    assign try_next   = try_cnt + CNT_W'(1);
    assign match_next = match ? (match_cnt + CNT_W'(1)) : '0;
    assign clr_next   = clr_cnt + CLR_W'(1);
    assign read_ready = (state == ST_IDLE);

    // counter_clear resets high so the counter is held clear while in reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            try_cnt        <= '0;
            match_cnt      <= '0;
            clr_cnt        <= '0;
            read_valid     <= 1'b0;
            read_value     <= '0;
            read_error     <= 1'b0;
            clear_done     <= 1'b0;
            counter_enable <= 1'b0;
            counter_clear  <= 1'b1;
        end else begin
            read_valid     <= 1'b0;
            clear_done     <= 1'b0;
            counter_enable <= count_enable;
            case (state)
                ST_IDLE: begin
                    counter_clear <= 1'b0;
                    if (clear_req) begin
                        state          <= ST_CLEAR;
                        clr_cnt        <= '0;
                        counter_clear  <= 1'b1;
                        counter_enable <= 1'b0;
                    end else if (read_req) begin
                        state     <= ST_SAMPLE;
                        try_cnt   <= '0;
                        match_cnt <= '0;
                    end
                end
                ST_SAMPLE: begin
                    try_cnt   <= try_next;
                    match_cnt <= match_next;
                    if (match_next == STABLE_N) begin
                        read_value <= sync;
                        read_error <= 1'b0;
                        state      <= ST_DONE;
                    end else if (try_next == TRIES_N) begin
                        read_value <= sync;
                        read_error <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_CLEAR: begin
                    counter_enable <= 1'b0;
                    clr_cnt        <= clr_next;
                    if (clr_next == CLEAR_N) begin
                        counter_clear <= 1'b0;
                        try_cnt       <= '0;
                        state         <= ST_CLEAR_WAIT;
                    end
                end
                ST_CLEAR_WAIT: begin
                    try_cnt <= try_next;
                    if (sync_zero) begin
                        read_error <= 1'b0;
                        clear_done <= 1'b1;
                        state      <= ST_IDLE;
                    end else if (try_next == TRIES_N) begin
                        read_error <= 1'b1;
                        clear_done <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        counter_enable <= 1'b0;
                    end
                end
                ST_DONE: begin
                    read_valid <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_reader.sv
// Randomized bench for counter_reader against a history-based model of the counter value.
module tb_counter_reader;

    localparam int STABLE = 2;
    localparam int TRIES  = 16;
    localparam int CLRC   = 2;
    localparam int HIST_N = 8192;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] count_in;
    logic        count_enable = 1'b0;
    logic        read_req = 1'b0;
    logic        clear_req = 1'b0;
    logic        read_ready;
    logic        read_valid;
    logic [31:0] read_value;
    logic        read_error;
    logic        clear_done;
    logic        counter_enable;
    logic        counter_clear;

    int checks = 0;
    int errors = 0;

    counter_reader #(
        .WIDTH          (32),
        .STABLE_SAMPLES (STABLE),
        .MAX_TRIES      (TRIES),
        .CLEAR_CYCLES   (CLRC)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .count_in       (count_in),
        .count_enable   (count_enable),
        .read_req       (read_req),
        .clear_req      (clear_req),
        .read_ready     (read_ready),
        .read_valid     (read_valid),
        .read_value     (read_value),
        .read_error     (read_error),
        .clear_done     (clear_done),
        .counter_enable (counter_enable),
        .counter_clear  (counter_clear)
    );

    always #5 clk = ~clk;

    // Asynchronous counter model: mode 0 hold, 1 change every cycle, 2 change at random, 3 load.
    int          mode = 0;
    logic [31:0] load_val = '0;
    bit          clear_ignored = 1'b0;
    logic [31:0] cnt_val = '0;

    assign count_in = (counter_clear && !clear_ignored) ? '0 : cnt_val;

    always @(negedge clk) begin
        if (counter_clear && !clear_ignored) cnt_val <= '0;
        else begin
            case (mode)
                1: cnt_val <= cnt_val + 32'd1 + 32'($urandom_range(0, 254));
                2: if ($urandom_range(0, 2) == 0) cnt_val <= $urandom;
                3: cnt_val <= load_val;
                default: ;
            endcase
        end
    end

    // hist[e] is the counter value seen by the DUT at rising edge number e.
    int          cyc = 0;
    logic [31:0] hist [0:HIST_N-1];

    always @(posedge clk) begin
        if (cyc < HIST_N) hist[cyc] <= count_in;
        cyc <= cyc + 1;
    end

    // Read accepted at edge a: the snapshot is the first synchronized value that has been
    // seen unchanged over STABLE consecutive comparisons, or whatever is there after TRIES.
    function automatic void model_read(input int a, output int vedge, output logic [31:0] val,
                                       output bit err);
        int run;
        run = 0; vedge = -1; val = '0; err = 1'b0;
        for (int j = 1; j <= TRIES; j++) begin
            if (hist[a+j-2] == hist[a+j-3]) run++;
            else run = 0;
            if (run == STABLE) begin
                vedge = a + j + 1; val = hist[a+j-2]; err = 1'b0;
                return;
            end
            if (j == TRIES) begin
                vedge = a + j + 1; val = hist[a+j-2]; err = 1'b1;
                return;
            end
        end
    endfunction

    // Clear accepted at edge a: done when two consecutive synchronized values are zero.
    function automatic void model_clear(input int a, output int vedge, output bit err);
        int e;
        vedge = -1; err = 1'b0;
        for (int k = 1; k <= TRIES; k++) begin
            e = a + CLRC + k;
            if (hist[e-2] == 0 && hist[e-3] == 0) begin
                vedge = e; err = 1'b0;
                return;
            end
            if (k == TRIES) begin
                vedge = e; err = 1'b1;
                return;
            end
        end
    endfunction

    task automatic wait_pulse(input bit want_clear, output int edge_seen, output logic [31:0] val,
                              output logic err);
        edge_seen = -1; val = 'x; err = 1'bx;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (want_clear ? clear_done : read_valid) begin
                edge_seen = cyc - 1; val = read_value; err = read_error;
                return;
            end
        end
    endtask

    task automatic do_read(input string name, input bit use_const, input int const_lat,
                           input logic [31:0] const_val, input bit const_err);
        int a, e, ve;
        logic [31:0] v, mv;
        logic er;
        bit me;
        read_req = 1'b1; a = cyc;
        @(negedge clk); read_req = 1'b0;
        wait_pulse(1'b0, e, v, er);
        model_read(a, ve, mv, me);
        checks++;
        if (e !== ve) begin
            errors++; $display("FAIL %s latency: valid at edge %0d, expected edge %0d", name, e, ve);
        end
        checks++;
        if (v !== mv) begin
            errors++; $display("FAIL %s value: got %h expected %h", name, v, mv);
        end
        checks++;
        if (er !== me) begin
            errors++; $display("FAIL %s error: got %b expected %b", name, er, me);
        end
        if (use_const) begin
            checks++;
            if (e !== a + const_lat || v !== const_val || er !== const_err) begin
                errors++;
                $display("FAIL %s fixed: edge %0d val %h err %b, expected edge %0d val %h err %b",
                         name, e, v, er, a + const_lat, const_val, const_err);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({read_ready, read_valid, read_error, clear_done, counter_enable, counter_clear} !== 6'b100001
            || read_value !== '0) begin
            errors++;
            $display("FAIL reset outputs: rdy/vld/err/done/en/clr=%b%b%b%b%b%b val=%h, expected 100001 val=0",
                     read_ready, read_valid, read_error, clear_done, counter_enable, counter_clear, read_value);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (counter_clear !== 1'b0 || read_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset release: counter_clear=%b read_ready=%b, expected 0 1", counter_clear, read_ready);
        end
    endtask

    task automatic test_static_read();
        count_enable = 1'b1;
        load_val = 32'h1234_5678; mode = 3;
        repeat (5) @(negedge clk);
        mode = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (counter_enable !== 1'b1) begin
            errors++; $display("FAIL enable follow: got %b expected 1", counter_enable);
        end
        do_read("static", 1'b1, STABLE + 1, 32'h1234_5678, 1'b0);
    endtask

    task automatic test_changing_read();
        int a, e;
        logic [31:0] v;
        logic er;
        mode = 1;
        repeat (3) @(negedge clk);
        read_req = 1'b1; a = cyc;
        @(negedge clk); read_req = 1'b0;
        checks++;
        if (read_ready !== 1'b0) begin
            errors++; $display("FAIL busy ready: got %b expected 0", read_ready);
        end
        wait_pulse(1'b0, e, v, er);
        checks++;
        if (e !== a + TRIES + 1 || er !== 1'b1 || v !== hist[a+TRIES-2]) begin
            errors++;
            $display("FAIL timeout read: edge %0d val %h err %b, expected edge %0d val %h err 1",
                     e, v, er, a + TRIES + 1, hist[a+TRIES-2]);
        end
        mode = 0;
    endtask

    task automatic test_random_reads();
        mode = 2;
        for (int n = 0; n < 12; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_read("random", 1'b0, 0, '0, 1'b0);
        end
        mode = 0;
    endtask

    task automatic test_clear(input bit ignored);
        int a, e, ve;
        logic [31:0] v;
        logic er;
        bit me;
        string name;
        name = ignored ? "clear_timeout" : "clear";
        load_val = ignored ? 32'd77 : 32'd100; mode = 3;
        repeat (3) @(negedge clk);
        mode = 0; clear_ignored = ignored;
        @(negedge clk);
        clear_req = 1'b1; a = cyc;
        @(negedge clk); clear_req = 1'b0;
        for (int i = 0; i < CLRC; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (counter_clear !== 1'b1 || counter_enable !== 1'b0) begin
                errors++;
                $display("FAIL %s pulse[%0d]: clear=%b enable=%b, expected 1 0", name, i, counter_clear, counter_enable);
            end
        end
        wait_pulse(1'b1, e, v, er);
        model_clear(a, ve, me);
        checks++;
        if (e !== ve || er !== me) begin
            errors++;
            $display("FAIL %s done: edge %0d err %b, expected edge %0d err %b", name, e, er, ve, me);
        end
        checks++;
        if (e !== (ignored ? a + CLRC + TRIES : a + CLRC + 2)) begin
            errors++;
            $display("FAIL %s latency: edge %0d expected %0d", name, e, ignored ? a + CLRC + TRIES : a + CLRC + 2);
        end
        clear_ignored = 1'b0;
    endtask

    task automatic test_both_and_busy();
        int vcnt, dcnt;
        load_val = 32'd55; mode = 3;
        repeat (3) @(negedge clk);
        mode = 0;
        clear_req = 1'b1; read_req = 1'b1;
        @(negedge clk); clear_req = 1'b0; read_req = 1'b0;
        checks++;
        if (counter_clear !== 1'b1) begin
            errors++; $display("FAIL priority clear: counter_clear=%b expected 1", counter_clear);
        end
        vcnt = 0; dcnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (read_valid) vcnt++;
            if (clear_done) dcnt++;
        end
        checks++;
        if (vcnt !== 0 || dcnt !== 1) begin
            errors++; $display("FAIL priority pulses: valid=%0d done=%0d, expected 0 1", vcnt, dcnt);
        end
        mode = 1;
        repeat (2) @(negedge clk);
        read_req = 1'b1;
        @(negedge clk); read_req = 1'b0;
        @(negedge clk); read_req = 1'b1;
        @(negedge clk); read_req = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (read_valid) vcnt++;
        end
        checks++;
        if (vcnt !== 1) begin
            errors++; $display("FAIL busy ignore: valid pulses=%0d expected 1", vcnt);
        end
        mode = 0;
    endtask

    task automatic test_wrap();
        load_val = 32'hFFFF_FFFF; mode = 3;
        repeat (4) @(negedge clk);
        do_read("wrap_high", 1'b1, STABLE + 1, 32'hFFFF_FFFF, 1'b0);
        load_val = 32'h0000_0000;
        repeat (4) @(negedge clk);
        do_read("wrap_zero", 1'b1, STABLE + 1, 32'h0000_0000, 1'b0);
        mode = 0;
    endtask

    task automatic test_reset_mid();
        int vcnt;
        mode = 1;
        repeat (2) @(negedge clk);
        read_req = 1'b1;
        @(negedge clk); read_req = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({read_ready, read_valid, read_error, clear_done, counter_enable, counter_clear} !== 6'b100001
            || read_value !== '0) begin
            errors++;
            $display("FAIL mid reset outputs: rdy/vld/err/done/en/clr=%b%b%b%b%b%b val=%h, expected 100001 val=0",
                     read_ready, read_valid, read_error, clear_done, counter_enable, counter_clear, read_value);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (read_valid) vcnt++;
        end
        checks++;
        if (vcnt !== 0 || counter_clear !== 1'b0) begin
            errors++;
            $display("FAIL mid reset after: valid pulses=%0d counter_clear=%b, expected 0 0", vcnt, counter_clear);
        end
        mode = 0;
    endtask

    initial begin
        test_reset();
        test_static_read();
        test_changing_read();
        test_random_reads();
        test_clear(1'b0);
        test_clear(1'b1);
        test_both_and_busy();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
